// File: rtl/cpu_step_controller.sv
// Single-step / run / burst clock-enable controller for a debug CPU, fed by three raw buttons.
// Define CPU_STEP_COUNTER_EN to build the step_count counter; otherwise step_count is tied to 0.
module cpu_step_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_step,
    input  logic             btn_run,
    input  logic             btn_burst,
    input  logic [7:0]       burst_len,
    output logic             cpu_en,
    output logic             halted,
    output logic [1:0]       mode,
    output logic [CNT_W-1:0] step_count
);
    localparam logic [1:0] S_HALT  = 2'b00;
    localparam logic [1:0] S_STEP  = 2'b01;
    localparam logic [1:0] S_RUN   = 2'b10;
    localparam logic [1:0] S_BURST = 2'b11;
    localparam int         NB      = 3;
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [NB-1:0] btn_raw, sync1_q, sync2_q, level_q, level_prev_q, evt;
    logic          step_evt, run_evt, burst_evt;
    logic [1:0]    state_q, state_d;
    logic [7:0]    rem_q, rem_d;

    assign btn_raw = {btn_burst, btn_run, btn_step};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_prev_q <= '0;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            level_prev_q <= level_q;
        end
    end

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples; agreement restarts the count.
    for (genvar b = 0; b < NB; b++) begin : g_db
        logic [7:0] cnt_q;
        logic       lvl_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else if (sync2_q[b] == lvl_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DB_LAST) begin
                cnt_q <= '0;
                lvl_q <= sync2_q[b];
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
        end

        assign level_q[b] = lvl_q;
    end

    assign evt       = level_q & ~level_prev_q;
    assign step_evt  = evt[0];
    assign run_evt   = evt[1];
    assign burst_evt = evt[2];

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            S_HALT: begin
                // A burst event masks a same-cycle step even when burst_len is 0.
                if (run_evt) begin
                    state_d = S_RUN;
                end else if (burst_evt) begin
                    if (burst_len != 8'd0) begin
                        state_d = S_BURST;
                        rem_d   = burst_len;
                    end
                end else if (step_evt) begin
                    state_d = S_STEP;
                end
            end
            S_STEP: state_d = S_HALT;
            S_RUN: begin
                if (run_evt) state_d = S_HALT;
            end
            S_BURST: begin
                rem_d = rem_q - 8'd1;
                if (run_evt) begin
                    state_d = S_HALT;
                    rem_d   = 8'd0;
                end else if (rem_q == 8'd1) begin
                    state_d = S_HALT;
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_HALT;
            rem_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    assign cpu_en = (state_q != S_HALT);
    assign halted = (state_q == S_HALT);
    assign mode   = state_q;

`ifdef CPU_STEP_COUNTER_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      cnt_q <= '0;
        else if (cpu_en) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign step_count = cnt_q;
`else
    assign step_count = '0;
`endif

endmodule

// File: tb/tb_cpu_step_controller.sv
// Scoreboard bench for cpu_step_controller: per-cycle expected cpu_en/mode queued with stimulus, popped on sampling.
module tb_cpu_step_controller;
    logic        clk, reset, btn_step, btn_run, btn_burst;
    logic [7:0]  burst_len;
    logic        cpu_en, halted;
    logic [1:0]  mode;
    logic [15:0] step_count;

    typedef struct packed {
        logic       en;
        logic [1:0] md;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_cnt = 0;

    cpu_step_controller #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .btn_step(btn_step), .btn_run(btn_run),
        .btn_burst(btn_burst), .burst_len(burst_len), .cpu_en(cpu_en),
        .halted(halted), .mode(mode), .step_count(step_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    function automatic logic [15:0] sc_exp();
`ifdef CPU_STEP_COUNTER_EN
        return exp_cnt[15:0];
`else
        return 16'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        btn_step = 1'b0; btn_run = 1'b0; btn_burst = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #2;
        n_tests++; if (cpu_en !== 1'b0)      begin n_fail++; $display("FAIL reset_async cpu_en got %b want 0", cpu_en); end
        n_tests++; if (halted !== 1'b1)      begin n_fail++; $display("FAIL reset_async halted got %b want 1", halted); end
        n_tests++; if (mode !== 2'b00)       begin n_fail++; $display("FAIL reset_async mode got %b want 00", mode); end
        n_tests++; if (step_count !== 16'd0) begin n_fail++; $display("FAIL reset_async step_count got %0d want 0", step_count); end
        tick(); tick();
        reset = 1'b1;
        tick();
        n_tests++; if (cpu_en !== 1'b0 || mode !== 2'b00) begin
            n_fail++; $display("FAIL reset_release cpu_en/mode got %b/%b want 0/00", cpu_en, mode);
        end
    endtask

    task automatic test_step();
        exp_t x;
        for (int k = 0; k < 16; k++) exp_q.push_back('{en: (k == 6), md: (k == 6) ? 2'b01 : 2'b00});
        for (int k = 0; k < 16; k++) begin
            btn_step = (k < 10);
            tick();
            x = exp_q.pop_front();
            n_tests++; if (cpu_en !== x.en)          begin n_fail++; $display("FAIL step_cpu_en k=%0d got %b want %b", k, cpu_en, x.en); end
            n_tests++; if (mode !== x.md)            begin n_fail++; $display("FAIL step_mode k=%0d got %b want %b", k, mode, x.md); end
            n_tests++; if (step_count !== sc_exp())  begin n_fail++; $display("FAIL step_count k=%0d got %0d want %0d", k, step_count, sc_exp()); end
            if (x.en) exp_cnt++;
        end
        btn_step = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_burst();
        exp_t x;
        do_reset();
        for (int k = 0; k < 20; k++) exp_q.push_back('{en: (k >= 6 && k <= 10), md: (k >= 6 && k <= 10) ? 2'b11 : 2'b00});
        for (int k = 0; k < 20; k++) begin
            btn_burst = (k < 8);
            burst_len = (k <= 6) ? 8'd5 : 8'd9;
            tick();
            x = exp_q.pop_front();
            n_tests++; if (cpu_en !== x.en)         begin n_fail++; $display("FAIL burst_cpu_en k=%0d got %b want %b", k, cpu_en, x.en); end
            n_tests++; if (mode !== x.md)           begin n_fail++; $display("FAIL burst_mode k=%0d got %b want %b", k, mode, x.md); end
            n_tests++; if (step_count !== sc_exp()) begin n_fail++; $display("FAIL burst_count k=%0d got %0d want %0d", k, step_count, sc_exp()); end
            if (x.en) exp_cnt++;
        end
`ifdef CPU_STEP_COUNTER_EN
        n_tests++; if (step_count !== 16'd5) begin n_fail++; $display("FAIL burst_total got %0d want 5", step_count); end
`endif
        burst_len = 8'd0;
        for (int k = 0; k < 20; k++) exp_q.push_back('{en: 1'b0, md: 2'b00});
        for (int k = 0; k < 20; k++) begin
            btn_burst = (k < 8);
            tick();
            x = exp_q.pop_front();
            n_tests++; if (cpu_en !== x.en || mode !== x.md) begin
                n_fail++; $display("FAIL burst_zero k=%0d cpu_en/mode got %b/%b want %b/%b", k, cpu_en, mode, x.en, x.md);
            end
        end
        n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL burst_zero_halted got %b want 1", halted); end
    endtask

    task automatic test_run();
        exp_t x;
        do_reset();
        for (int k = 0; k < 46; k++) exp_q.push_back('{en: (k >= 6 && k <= 32), md: (k >= 6 && k <= 32) ? 2'b10 : 2'b00});
        for (int k = 0; k < 46; k++) begin
            btn_run  = (k < 8) || (k >= 27 && k < 35);
            btn_step = (k >= 11 && k < 19);
            tick();
            x = exp_q.pop_front();
            n_tests++; if (cpu_en !== x.en)         begin n_fail++; $display("FAIL run_cpu_en k=%0d got %b want %b", k, cpu_en, x.en); end
            n_tests++; if (mode !== x.md)           begin n_fail++; $display("FAIL run_mode k=%0d got %b want %b", k, mode, x.md); end
            n_tests++; if (step_count !== sc_exp()) begin n_fail++; $display("FAIL run_count k=%0d got %0d want %0d", k, step_count, sc_exp()); end
            if (x.en) exp_cnt++;
        end
        n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL run_halted got %b want 1", halted); end
    endtask

    task automatic test_bounce();
        exp_t x;
        for (int k = 0; k < 24; k++) exp_q.push_back('{en: 1'b0, md: 2'b00});
        for (int k = 0; k < 24; k++) begin
            btn_step = (k < 12) ? (((k / 2) % 2) == 0) : 1'b0;
            tick();
            x = exp_q.pop_front();
            n_tests++; if (cpu_en !== x.en || mode !== x.md) begin
                n_fail++; $display("FAIL bounce k=%0d cpu_en/mode got %b/%b want %b/%b", k, cpu_en, mode, x.en, x.md);
            end
        end
    endtask

    task automatic test_simul();
        exp_t x;
        do_reset();
        for (int k = 0; k < 15; k++) exp_q.push_back('{en: (k >= 6), md: (k >= 6) ? 2'b10 : 2'b00});
        for (int k = 0; k < 15; k++) begin
            btn_run  = (k < 8);
            btn_step = (k < 8);
            tick();
            x = exp_q.pop_front();
            n_tests++; if (cpu_en !== x.en || mode !== x.md) begin
                n_fail++; $display("FAIL simul k=%0d cpu_en/mode got %b/%b want %b/%b", k, cpu_en, mode, x.en, x.md);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        exp_t x;
        do_reset();
        burst_len = 8'd200;
        for (int k = 0; k < 20; k++) exp_q.push_back('{en: (k >= 6), md: (k >= 6) ? 2'b11 : 2'b00});
        for (int k = 0; k < 20; k++) begin
            btn_burst = (k < 8);
            tick();
            x = exp_q.pop_front();
            n_tests++; if (cpu_en !== x.en || mode !== x.md) begin
                n_fail++; $display("FAIL midburst k=%0d cpu_en/mode got %b/%b want %b/%b", k, cpu_en, mode, x.en, x.md);
            end
        end
        #2 reset = 1'b0;
        exp_cnt = 0;
        #1;
        n_tests++; if (cpu_en !== 1'b0)      begin n_fail++; $display("FAIL midburst_reset cpu_en got %b want 0", cpu_en); end
        n_tests++; if (step_count !== 16'd0) begin n_fail++; $display("FAIL midburst_reset step_count got %0d want 0", step_count); end
        n_tests++; if (halted !== 1'b1 || mode !== 2'b00) begin
            n_fail++; $display("FAIL midburst_reset halted/mode got %b/%b want 1/00", halted, mode);
        end
        tick();
        n_tests++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL midburst_hold cpu_en got %b want 0", cpu_en); end
    endtask

    task automatic test_reset_release();
        exp_t x;
        reset = 1'b0;
        btn_burst = 1'b0; btn_run = 1'b0; btn_step = 1'b1;
        exp_q.delete();
        exp_cnt = 0;
        tick(); tick();
        #3 reset = 1'b1;
        for (int k = 0; k < 16; k++) exp_q.push_back('{en: (k == 6), md: (k == 6) ? 2'b01 : 2'b00});
        for (int k = 0; k < 16; k++) begin
            btn_step = (k < 10);
            tick();
            x = exp_q.pop_front();
            n_tests++; if (cpu_en !== x.en || mode !== x.md) begin
                n_fail++; $display("FAIL held_release k=%0d cpu_en/mode got %b/%b want %b/%b", k, cpu_en, mode, x.en, x.md);
            end
        end
    endtask

    task automatic test_wrap();
        bit done;
        do_reset();
`ifdef CPU_STEP_COUNTER_EN
        for (int k = 0; k < 7; k++) begin
            btn_run = 1'b1;
            tick();
        end
        n_tests++; if (cpu_en !== 1'b1 || step_count !== 16'd0) begin
            n_fail++; $display("FAIL wrap_start cpu_en/count got %b/%0d want 1/0", cpu_en, step_count);
        end
        for (int n = 1; n <= 65537; n++) begin
            btn_run = (n == 1);
            tick();
            if (n == 65535) begin
                n_tests++; if (step_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_max got %0d want 65535", step_count); end
            end
            if (n == 65536) begin
                n_tests++; if (step_count !== 16'd0) begin n_fail++; $display("FAIL wrap_zero got %0d want 0", step_count); end
            end
        end
        n_tests++; if (step_count !== 16'd1 || cpu_en !== 1'b1) begin
            n_fail++; $display("FAIL wrap_one count/cpu_en got %0d/%b want 1/1", step_count, cpu_en);
        end
`else
        for (int n = 0; n < 300; n++) begin
            btn_run = (n < 8);
            tick();
            n_tests++; if (step_count !== 16'd0) begin n_fail++; $display("FAIL nocount n=%0d got %0d want 0", n, step_count); end
        end
        n_tests++; if (cpu_en !== 1'b1) begin n_fail++; $display("FAIL nocount_run cpu_en got %b want 1", cpu_en); end
`endif
        done = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            btn_run = (k < 8);
            tick();
            if (halted === 1'b1) done = 1'b1;
        end
        btn_run = 1'b0;
        n_tests++; if (!done) begin n_fail++; $display("FAIL wrap_stop halted got %b want 1 within 30 cycles", halted); end
    endtask

    initial begin
        reset = 1'b1;
        btn_step = 1'b0; btn_run = 1'b0; btn_burst = 1'b0;
        burst_len = 8'd0;
        test_reset();
        test_step();
        test_burst();
        test_run();
        test_bounce();
        test_simul();
        test_reset_mid_burst();
        test_reset_release();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
